// File: rtl/suite_video_pkg.sv
// Shared raster types and helpers for the 240p test-suite video generator.
package suite_video_pkg;

  typedef enum logic [1:0] {H_ST_ACTIVE, H_ST_FRONT, H_ST_SYNC, H_ST_BACK} h_state_t;
  typedef enum logic [1:0] {V_ST_ACTIVE, V_ST_FRONT, V_ST_SYNC, V_ST_BACK} v_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic int raster_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic rgb888_t rgb332_expand(input logic [7:0] p);
    rgb888_t c;
    c.r = {p[7:5], p[7:5], p[7:6]};
    c.g = {p[4:2], p[4:2], p[4:3]};
    c.b = {4{p[1:0]}};
    return c;
  endfunction

endpackage

// File: rtl/suite_layer_mix.sv
// Combinational priority compositor: highest-index enabled opaque layer wins, else background.
module suite_layer_mix #(
  parameter int LAYERS = 2
) (
  input  logic [LAYERS-1:0]   en_i,
  input  logic [8*LAYERS-1:0] data_i,
  input  logic [7:0]          bg_i,
  output logic [7:0]          pix_o
);

  // Later (higher-index) layers overwrite earlier ones, giving top priority to the highest index.
  always_comb begin
    pix_o = bg_i;
    for (int i = 0; i < LAYERS; i++) begin
      if (en_i[i] && (data_i[8*i +: 8] != 8'h00)) pix_o = data_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/suite_raster_gen.sv
// Raster timing, pattern-ROM addressing and layer compositing for the 240p suite.
// Define SUITE_INTERLACE_EN to add the interlace input and field output.
//
//  state        | meaning
//  H_ST_ACTIVE  | visible pixels of the line
//  H_ST_FRONT   | horizontal front porch
//  H_ST_SYNC    | horizontal sync pulse
//  H_ST_BACK    | horizontal back porch
//  V_ST_*       | same phases for lines within the frame
module suite_raster_gen
  import suite_video_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_ACT   = 320,
  parameter int H_FP    = 8,
  parameter int H_SYNC  = 32,
  parameter int H_BP    = 32,
  parameter int V_ACT   = 240,
  parameter int V_FP    = 6,
  parameter int V_SYNC  = 8,
  parameter int V_BP    = 12,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b1,
  parameter int LAYERS  = 2,
  parameter int AW      = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LAYERS-1:0]   layer_en,
  input  logic [8*LAYERS-1:0] layer_data,
  input  logic [7:0]          bg_color,
  output logic [AW-1:0]       vram_addr,
  output logic                ce_pix,
  output logic                h_blank,
  output logic                v_blank,
  output logic                h_sync,
  output logic                v_sync,
  output logic                de,
  output logic                frame_start,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b
`ifdef SUITE_INTERLACE_EN
  ,
  input  logic                interlace,
  output logic                field
`endif
);

  localparam int HTOTAL   = raster_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int VTOTAL   = raster_total(V_ACT, V_FP, V_SYNC, V_BP);
  localparam int HW       = $clog2(HTOTAL);
  localparam int VW       = $clog2(VTOTAL + 1);
  localparam int DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACT + H_FP;
  localparam int VS_START = V_ACT + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (CLK_DIV < 2) begin : g_bad_div
    $error("suite_raster_gen: CLK_DIV must be >= 2");
  end
  if (LAYERS < 1 || LAYERS > 8) begin : g_bad_layers
    $error("suite_raster_gen: LAYERS must be 1..8");
  end
  if ((2 ** AW) < (H_ACT * V_ACT)) begin : g_bad_aw
    $error("suite_raster_gen: AW too small for H_ACT*V_ACT");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("suite_raster_gen: porch and sync widths must be >= 1");
  end

  logic [DW-1:0] div_q;
  logic          ce_pix_q;
  logic          tick;
  logic [HW-1:0] hc_q;
  logic [VW-1:0] vc_q;
  logic [VW-1:0] v_last;
  h_state_t      h_state_q;
  v_state_t      v_state_q;
  logic          line_end;
  logic          frame_end;
  logic          odd;
  logic [AW-1:0] addr_q;
  logic          active_px;
  logic [HW-1:0] vs_off;
  logic          vs_win;
  logic [7:0]    mix_pix;
  rgb888_t       rgb_d;
  rgb888_t       rgb_q;
  logic          de_q, h_blank_q, v_blank_q, h_sync_q, v_sync_q, frame_start_q;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      ce_pix_q <= 1'b0;
    end else begin
      ce_pix_q <= tick;
      div_q    <= tick ? '0 : div_q + 1'b1;
    end
  end

  assign line_end  = tick && (hc_q == HW'(HTOTAL - 1));
  assign frame_end = line_end && (vc_q == v_last);
  assign v_last    = odd ? VW'(VTOTAL) : VW'(VTOTAL - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q      <= '0;
      h_state_q <= H_ST_ACTIVE;
    end else if (tick) begin
      hc_q <= line_end ? '0 : hc_q + 1'b1;
      unique case (h_state_q)
        H_ST_ACTIVE: if (hc_q == HW'(H_ACT - 1))              h_state_q <= H_ST_FRONT;
        H_ST_FRONT:  if (hc_q == HW'(HS_START - 1))           h_state_q <= H_ST_SYNC;
        H_ST_SYNC:   if (hc_q == HW'(HS_START + H_SYNC - 1))  h_state_q <= H_ST_BACK;
        H_ST_BACK:   if (hc_q == HW'(HTOTAL - 1))             h_state_q <= H_ST_ACTIVE;
        default:                                              h_state_q <= H_ST_ACTIVE;
      endcase
    end
  end

  // The odd interlaced field carries its extra line at the end of the back porch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc_q      <= '0;
      v_state_q <= V_ST_ACTIVE;
    end else if (line_end) begin
      vc_q <= frame_end ? '0 : vc_q + 1'b1;
      unique case (v_state_q)
        V_ST_ACTIVE: if (vc_q == VW'(V_ACT - 1))    v_state_q <= V_ST_FRONT;
        V_ST_FRONT:  if (vc_q == VW'(VS_START - 1)) v_state_q <= V_ST_SYNC;
        V_ST_SYNC:   if (vc_q == VW'(VS_END - 1))   v_state_q <= V_ST_BACK;
        V_ST_BACK:   if (vc_q == v_last)            v_state_q <= V_ST_ACTIVE;
        default:                                    v_state_q <= V_ST_ACTIVE;
      endcase
    end
  end

`ifdef SUITE_INTERLACE_EN
  logic field_q;
  logic field_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      field_q     <= 1'b0;
      field_out_q <= 1'b0;
    end else begin
      if (frame_end) field_q <= interlace ? ~field_q : 1'b0;
      if (tick)      field_out_q <= field_q;
    end
  end

  assign odd   = field_q;
  assign field = field_out_q;
`else
  assign odd = 1'b0;
`endif

  assign active_px = (h_state_q == H_ST_ACTIVE) && (v_state_q == V_ST_ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else if (tick && active_px) begin
      if ((hc_q == HW'(H_ACT - 1)) && (vc_q == VW'(V_ACT - 1))) addr_q <= '0;
      else                                                      addr_q <= addr_q + 1'b1;
    end
  end

  // v_sync edges land on the h_sync leading edge, or mid-line in the odd field.
  always_comb begin
    vs_off = odd ? HW'(HTOTAL / 2) : HW'(HS_START);
    if (vc_q == VW'(VS_START))                             vs_win = (hc_q >= vs_off);
    else if ((vc_q > VW'(VS_START)) && (vc_q < VW'(VS_END))) vs_win = 1'b1;
    else if (vc_q == VW'(VS_END))                          vs_win = (hc_q < vs_off);
    else                                                   vs_win = 1'b0;
  end

  suite_layer_mix #(.LAYERS(LAYERS)) u_mix (
    .en_i  (layer_en),
    .data_i(layer_data),
    .bg_i  (bg_color),
    .pix_o (mix_pix)
  );

  assign rgb_d = active_px ? rgb332_expand(mix_pix) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q          <= 1'b0;
      h_blank_q     <= 1'b1;
      v_blank_q     <= 1'b1;
      h_sync_q      <= ~HS_POL;
      v_sync_q      <= ~VS_POL;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else if (tick) begin
      de_q          <= active_px;
      h_blank_q     <= (h_state_q != H_ST_ACTIVE);
      v_blank_q     <= (v_state_q != V_ST_ACTIVE);
      h_sync_q      <= (h_state_q == H_ST_SYNC) ? HS_POL : ~HS_POL;
      v_sync_q      <= vs_win ? VS_POL : ~VS_POL;
      frame_start_q <= (hc_q == '0) && (vc_q == '0);
      rgb_q         <= rgb_d;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign vram_addr   = addr_q;
  assign ce_pix      = ce_pix_q;
  assign de          = de_q;
  assign h_blank     = h_blank_q;
  assign v_blank     = v_blank_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign frame_start = frame_start_q;
  assign r           = rgb_q.r;
  assign g           = rgb_q.g;
  assign b           = rgb_q.b;

endmodule

// File: tb/tb_suite_raster_gen.sv
// Bench for suite_raster_gen on a shrunken raster: random ROM tables and layer/background
// changes, every output pixel compared against an arithmetic raster model.
module tb_suite_raster_gen;
  localparam int CD = 3;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int NPIX = HA * VA;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  layer_en;
  logic [15:0] layer_data;
  logic [7:0]  bg_color;
  logic [7:0]  vram_addr;
  logic        ce_pix, h_blank, v_blank, h_sync, v_sync, de, frame_start;
  logic [7:0]  r, g, b;
`ifdef SUITE_INTERLACE_EN
  logic        interlace = 1'b0;
  logic        field;
`endif

  int          total = 0;
  int          bad = 0;
  logic [7:0]  tbl0 [256];
  logic [7:0]  tbl1 [256];
  bit          rom_const;
  logic [7:0]  c0, c1;
  int          p;
  int          de_cnt;
  int          addr_max;
  logic [36:0] last_bundle;

  suite_raster_gen #(
    .CLK_DIV(CD), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .LAYERS(2), .AW(8)
  ) dut (
    .clk(clk), .reset(reset), .layer_en(layer_en), .layer_data(layer_data),
    .bg_color(bg_color), .vram_addr(vram_addr), .ce_pix(ce_pix),
    .h_blank(h_blank), .v_blank(v_blank), .h_sync(h_sync), .v_sync(v_sync),
    .de(de), .frame_start(frame_start), .r(r), .g(g), .b(b)
`ifdef SUITE_INTERLACE_EN
    , .interlace(interlace), .field(field)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous pattern ROMs with one clock of read latency.
  always @(posedge clk)
    layer_data <= rom_const ? {c1, c0} : {tbl1[vram_addr], tbl0[vram_addr]};

  function automatic logic [23:0] expand(input logic [7:0] q);
    return {q[7:5], q[7:5], q[7:6], q[4:2], q[4:2], q[4:3], {4{q[1:0]}}};
  endfunction

  function automatic logic [7:0] compose(input logic [1:0] en, input logic [7:0] d1,
                                         input logic [7:0] d0, input logic [7:0] bgc);
    if (en[1] && d1 != 8'h00) return d1;
    if (en[0] && d0 != 8'h00) return d0;
    return bgc;
  endfunction

  function automatic logic [36:0] bundle();
    return {vram_addr, de, h_blank, v_blank, h_sync, v_sync, r, g, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, vram_addr, 0);
    chk({tag, "_ce"}, ce_pix, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hblank"}, h_blank, 1);
    chk({tag, "_vblank"}, v_blank, 1);
    chk({tag, "_hsync"}, h_sync, !HP);
    chk({tag, "_vsync"}, v_sync, !VP);
    chk({tag, "_fstart"}, frame_start, 0);
    chk({tag, "_rgb"}, {r, g, b}, 24'h0);
  endtask

  task automatic step_ce();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!ce_pix && n < CD) begin
        chk("hold_between_ce", bundle(), last_bundle);
        chk("fstart_pulse", frame_start, 0);
      end
    end while (!ce_pix && n < 4 * CD);
    chk("ce_period", n, CD);
    last_bundle = bundle();
  endtask

  task automatic check_pixel();
    int hc, vc, t, a, nb;
    bit act;
    logic [7:0] d0, d1;
    logic [23:0] exp_rgb;
    hc  = p % HT;
    vc  = (p / HT) % VT;
    act = (hc < HA) && (vc < VA);
    a   = (vc * HA + hc) % 256;
    d0  = rom_const ? c0 : tbl0[a];
    d1  = rom_const ? c1 : tbl1[a];
    exp_rgb = act ? expand(compose(layer_en, d1, d0, bg_color)) : 24'h0;
    t   = vc * HT + hc;
    chk("de", de, act);
    chk("h_blank", h_blank, !(hc < HA));
    chk("v_blank", v_blank, !(vc < VA));
    chk("h_sync", h_sync, (hc >= HA + HF && hc < HA + HF + HS) ? HP : !HP);
    chk("v_sync", v_sync, (t >= (VA + VF) * HT + HA + HF && t < (VA + VF + VS) * HT + HA + HF) ? VP : !VP);
    chk("frame_start", frame_start, (hc == 0 && vc == 0));
    chk("rgb", {r, g, b}, exp_rgb);
    hc = (p + 1) % HT;
    vc = ((p + 1) / HT) % VT;
    nb = (vc >= VA) ? 0 : (vc * HA + ((hc < HA) ? hc : HA)) % NPIX;
    chk("vram_addr", vram_addr, nb);
    p++;
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (bad > 20) break;
      step_ce();
      if (p >= FR && p < 2 * FR) begin
        if (de) de_cnt++;
        if (int'(vram_addr) > addr_max) addr_max = int'(vram_addr);
      end
      check_pixel();
      if (rnd && $urandom_range(0, 7) == 0) begin
        layer_en = 2'($urandom_range(0, 3));
        bg_color = 8'($urandom);
      end
    end
  endtask

  initial begin
    rom_const = 1'b1;
    c0 = 8'hE0;
    c1 = 8'h00;
    layer_en = 2'b11;
    bg_color = 8'h03;
    p = 0;
    de_cnt = 0;
    addr_max = 0;
    for (int i = 0; i < 256; i++) begin
      tbl0[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      tbl1[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    @(negedge clk);
    reset = 1'b0;
    last_bundle = bundle();

    run(1, 1'b0);
    chk("mix_red", {r, g, b}, 24'hFF0000);
    c1 = 8'h1C;
    run(1, 1'b0);
    chk("mix_green", {r, g, b}, 24'h00FF00);
    layer_en = 2'b00;
    run(1, 1'b0);
    chk("mix_bg", {r, g, b}, 24'h0000FF);

    layer_en = 2'b01;
    rom_const = 1'b0;
    run(2 * FR + 40, 1'b1);
    chk("de_per_frame", de_cnt, NPIX);
    chk("addr_max", addr_max, NPIX - 1);

    for (int i = 0; i < FR && (p % FR) != 5 * HT + 10; i++) run(1, 1'b1);
    chk("reset_point", p % FR, 5 * HT + 10);
    reset = 1'b1;
    #1;
    chk_reset("mid");
    repeat (3) @(posedge clk);
    #1;
    chk_reset("mid_hold");
    @(negedge clk);
    reset = 1'b0;
    p = 0;
    last_bundle = bundle();
    run(FR + 30, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
